// File: rtl/da_const_mult_seq_pkg.sv
// Shared FSM encodings and sizing helpers for the distributed-arithmetic
// constant multiplier and its round/saturate output stage.
package da_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic int ncyc(input int in_w, input int bits_per_cycle);
    return in_w / bits_per_cycle;
  endfunction

  function automatic int prod_w(input int in_w, input int k_w);
    return in_w + k_w;
  endfunction

  // Signed range limits of a w-bit two's-complement value (w <= 64).
  function automatic longint smax(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint smin(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/da_const_mult_seq_if.sv
// Sample-in / result-out handshake bundle of the constant multiplier.
interface da_const_mult_seq_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_x;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_y;
  logic                    out_sat;
  logic                    busy;

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_y, out_sat, busy
  );

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_y, out_sat, busy
  );
endinterface

// File: rtl/da_const_mult_seq_round_sat.sv
// Round-half-up arithmetic right shift followed by an OUT_W range check with
// clamp or wrap; purely combinational so filter blocks can drop it in anywhere.
module da_round_sat
  import da_pkg::*;
#(
  parameter int IN_W_ACC  = 33,
  parameter int OUT_SHIFT = 0,
  parameter int OUT_W     = 32,
  parameter int SATURATE  = 1
) (
  input  logic signed [IN_W_ACC-1:0] acc_i,
  output logic signed [OUT_W-1:0]    y_o,
  output logic                       sat_o
);
  // One guard bit so the rounding increment can never wrap the sum.
  localparam int RW     = IN_W_ACC + 1;
  localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [RW-1:0] RND =
    (OUT_SHIFT > 0) ? ({{(RW-1){1'b0}}, 1'b1} << RND_SH) : {RW{1'b0}};
  localparam logic signed [OUT_W-1:0] Y_MAX = OUT_W'(smax(OUT_W));
  localparam logic signed [OUT_W-1:0] Y_MIN = OUT_W'(smin(OUT_W));

  logic signed [RW-1:0]    sum_s;
  logic signed [RW-1:0]    r_s;
  logic                    fits_s;
  logic signed [OUT_W-1:0] wrap_s;

  assign sum_s = RW'(acc_i) + RND;
  assign r_s   = sum_s >>> OUT_SHIFT;

  if (OUT_W >= RW) begin : g_wide
    assign fits_s = 1'b1;
    assign wrap_s = OUT_W'(r_s);
  end else begin : g_narrow
    logic [RW-OUT_W:0] top_s;
    assign top_s  = r_s[RW-1:OUT_W-1];
    assign fits_s = (&top_s) | ~(|top_s);
    assign wrap_s = r_s[OUT_W-1:0];
  end

  // Select in-range value, wrapped bits, or the clamp limit on the overflow side.
  always_comb begin
    sat_o = ~fits_s;
    if (fits_s || (SATURATE == 0)) begin
      y_o = wrap_s;
    end else if (r_s[RW-1]) begin
      y_o = Y_MIN;
    end else begin
      y_o = Y_MAX;
    end
  end

endmodule

// File: rtl/da_const_mult_seq.sv
// Multi-cycle y = K * x using shift-add over BITS_PER_CYCLE bits of x per
// clock, with valid/ready handshakes and an optional rounded, saturated output.
module da_const_mult_seq
  import da_pkg::*;
#(
  parameter int IN_W           = 16,
  parameter int K_W            = 16,
  parameter int K              = 2048,
  parameter int BITS_PER_CYCLE = 4,
  parameter int OUT_SHIFT      = 0,
  parameter int OUT_W          = 32,
  parameter int SATURATE       = 1
) (
  input logic              clk,
  input logic              rst,
  da_const_mult_seq_if.slave bus
);
  localparam int P_W   = prod_w(IN_W, K_W);
  localparam int AW    = P_W + 1;
  localparam int NCYC  = ncyc(IN_W, BITS_PER_CYCLE);
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(NCYC - 1);
  localparam logic signed [K_W-1:0] K_S      = K_W'(K);

  if ((IN_W % BITS_PER_CYCLE) != 0) begin : g_bpc_check
    $error("da_const_mult_seq: BITS_PER_CYCLE must divide IN_W");
  end

  logic [1:0]              state_q, state_d;
  logic [IN_W-1:0]         x_q, x_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [AW-1:0]    ksh_q, ksh_d;
  logic signed [AW-1:0]    pp_s;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_y_q, out_y_d;
  logic                    out_sat_q, out_sat_d;
  logic                    in_ready_q, busy_q;
  logic signed [OUT_W-1:0] rs_y_s;
  logic                    rs_sat_s;
  logic                    last_s;

  assign last_s = (cnt_q == CNT_LAST);

  // x is shifted down and K up each RUN cycle, so slice bit j always weighs K<<<j here;
  // the final bit of the final slice is the sign bit and is subtracted.
  always_comb begin
    pp_s = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (!x_q[j]) begin
        pp_s = pp_s;
      end else if (last_s && (j == BITS_PER_CYCLE - 1)) begin
        pp_s = pp_s - (ksh_q <<< j);
      end else begin
        pp_s = pp_s + (ksh_q <<< j);
      end
    end
  end

  // FSM next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    acc_d       = acc_q;
    ksh_d       = ksh_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.in_x;
          acc_d   = '0;
          ksh_d   = AW'(K_S);
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = acc_q + pp_s;
        ksh_d = ksh_q <<< BITS_PER_CYCLE;
        x_d   = x_q >> BITS_PER_CYCLE;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_s) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FIN: begin
        out_y_d     = rs_y_s;
        out_sat_d   = rs_sat_s;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; in_ready/busy are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      acc_q       <= '0;
      ksh_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_sat_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      ksh_q       <= ksh_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_sat_q   <= out_sat_d;
      in_ready_q  <= (state_d == ST_IDLE);
      busy_q      <= (state_d == ST_RUN) || (state_d == ST_FIN);
    end
  end

  da_round_sat #(
    .IN_W_ACC (AW),
    .OUT_SHIFT(OUT_SHIFT),
    .OUT_W    (OUT_W),
    .SATURATE (SATURATE)
  ) u_round_sat (
    .acc_i(acc_q),
    .y_o  (rs_y_s),
    .sat_o(rs_sat_s)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_da_const_mult_seq.sv
// Directed bench over several parameterisations of da_const_mult_seq with a
// scoreboard queue of expected results.
module tb_da_const_mult_seq;
  localparam int NDUT = 7;

  function automatic int k_of(input int g);
    case (g)
      1:       return -3;
      4:       return 8;
      5:       return -32768;
      6:       return 0;
      default: return 2048;
    endcase
  endfunction

  function automatic int bpc_of(input int g);
    return (g == 1) ? 1 : 4;
  endfunction

  function automatic int ow_of(input int g);
    return (g == 2 || g == 3) ? 16 : 32;
  endfunction

  function automatic int sat_of(input int g);
    return (g == 3) ? 0 : 1;
  endfunction

  function automatic int sh_of(input int g);
    return (g == 4) ? 4 : 0;
  endfunction

  typedef struct {
    int                 g;
    logic signed [31:0] y;
    logic               sat;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               vld  [NDUT];
  logic signed [15:0] xin  [NDUT];
  logic               ordy [NDUT];
  logic               ov   [NDUT];
  logic               os   [NDUT];
  logic               ir   [NDUT];
  logic               bz   [NDUT];
  logic signed [31:0] oy   [NDUT];

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int OW = ow_of(g);
    logic signed [OW-1:0] y_s;

    da_const_mult_seq_if #(.IN_W(16), .OUT_W(OW)) ifc ();

    da_const_mult_seq #(
      .IN_W(16), .K_W(16), .K(k_of(g)), .BITS_PER_CYCLE(bpc_of(g)),
      .OUT_SHIFT(sh_of(g)), .OUT_W(OW), .SATURATE(sat_of(g))
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc)
    );

    assign ifc.in_valid  = vld[g];
    assign ifc.in_x      = xin[g];
    assign ifc.out_ready = ordy[g];
    assign y_s           = ifc.out_y;
    assign oy[g]         = 32'(y_s);
    assign ov[g]         = ifc.out_valid;
    assign os[g]         = ifc.out_sat;
    assign ir[g]         = ifc.in_ready;
    assign bz[g]         = ifc.busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one sample into DUT g, push its expectation, wait for the result and score it.
  task automatic xact(input int g, input logic signed [15:0] x, input logic signed [31:0] ey,
                      input logic es, input int lat);
    exp_t e;
    int   n;
    logic bad;
    chk("in_ready_idle", 32'(ir[g]), 32'sd1);
    xin[g] = x;
    vld[g] = 1'b1;
    tick();
    vld[g] = 1'b0;
    xin[g] = ~x;
    sbq.push_back('{g, ey, es});
    n   = 0;
    bad = 1'b0;
    while (!ov[g] && n < 40) begin
      if (ir[g] || !bz[g]) begin
        bad = 1'b1;
      end
      tick();
      n++;
    end
    chk("latency", n, lat);
    chk("ready_low_busy_high", 32'(bad), 32'sd0);
    chk("done_ready_busy", 32'({ir[g], bz[g]}), 32'sd0);
    e = sbq.pop_front();
    chk("slot", e.g, g);
    chk("out_y", oy[g], e.y);
    chk("out_sat", 32'(os[g]), 32'(e.sat));
    if (ordy[g]) begin
      tick();
      chk("out_valid_drop", 32'(ov[g]), 32'sd0);
      chk("in_ready_back", 32'(ir[g]), 32'sd1);
    end
  endtask

  initial begin
    logic signed [15:0] rx;
    logic               quiet;

    for (int g = 0; g < NDUT; g++) begin
      vld[g]  = 1'b0;
      xin[g]  = 16'sd0;
      ordy[g] = 1'b1;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    for (int g = 0; g < NDUT; g++) begin
      chk("rst_out_valid", 32'(ov[g]), 32'sd0);
      chk("rst_out_y", oy[g], 32'sd0);
      chk("rst_out_sat", 32'(os[g]), 32'sd0);
      chk("rst_in_ready", 32'(ir[g]), 32'sd1);
      chk("rst_busy", 32'(bz[g]), 32'sd0);
    end

    // Defaults: K=2048, exact product
    xact(0, 16'sd3, 32'sd6144, 1'b0, 5);
    xact(0, 16'sh8000, -32'sd67108864, 1'b0, 5);
    xact(0, -16'sd1, -32'sd2048, 1'b0, 5);
    xact(0, 16'sh7FFF, 32'sd67106816, 1'b0, 5);
    for (int i = 0; i < 4; i++) begin
      rx = 16'($urandom_range(0, 65535));
      xact(0, rx, int'(rx) * 32'sd2048, 1'b0, 5);
    end

    // K=-3, one bit per cycle
    xact(1, -16'sd5, 32'sd15, 1'b0, 17);
    xact(1, 16'sh8000, 32'sd98304, 1'b0, 17);

    // OUT_W=16 saturating and wrapping
    xact(2, 16'sd100, 32'sd32767, 1'b1, 5);
    xact(2, -16'sd100, -32'sd32768, 1'b1, 5);
    xact(2, 16'sd16, 32'sd32767, 1'b1, 5);
    xact(2, 16'sd10, 32'sd20480, 1'b0, 5);
    xact(3, 16'sd100, 32'sd8192, 1'b1, 5);
    xact(3, -16'sd16, -32'sd32768, 1'b0, 5);

    // K=8 with OUT_SHIFT=4, round half up
    xact(4, 16'sd1, 32'sd1, 1'b0, 5);
    xact(4, -16'sd1, 32'sd0, 1'b0, 5);
    xact(4, 16'sd3, 32'sd2, 1'b0, 5);
    xact(4, -16'sd2, -32'sd1, 1'b0, 5);

    // Extreme coefficient and zero coefficient
    xact(5, 16'sh8000, 32'sd1073741824, 1'b0, 5);
    xact(5, 16'sh7FFF, -32'sd1073709056, 1'b0, 5);
    xact(6, -16'sd12345, 32'sd0, 1'b0, 5);

    // Backpressure in DONE: result held, new samples refused
    ordy[0] = 1'b0;
    xact(0, 16'sd5, 32'sd10240, 1'b0, 5);
    for (int i = 0; i < 10; i++) begin
      vld[0] = 1'b1;
      xin[0] = 16'sd7;
      tick();
      chk("hold_valid", 32'(ov[0]), 32'sd1);
      chk("hold_y", oy[0], 32'sd10240);
      chk("hold_ready", 32'(ir[0]), 32'sd0);
    end
    ordy[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    chk("release_valid", 32'(ov[0]), 32'sd0);
    chk("release_busy", 32'(bz[0]), 32'sd0);
    chk("release_ready", 32'(ir[0]), 32'sd1);
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ov[0] || bz[0]) begin
        quiet = 1'b0;
      end
    end
    chk("no_sample_from_done", 32'(quiet), 32'sd1);

    // Reset mid-RUN aborts the pending sample
    xin[0] = 16'sd9;
    vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    tick();
    tick();
    chk("run_busy", 32'(bz[0]), 32'sd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(bz[0]), 32'sd0);
    chk("abort_ready", 32'(ir[0]), 32'sd1);
    chk("abort_valid", 32'(ov[0]), 32'sd0);
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ov[0]) begin
        quiet = 1'b0;
      end
    end
    chk("abort_no_result", 32'(quiet), 32'sd1);
    xact(0, -16'sd7, -32'sd14336, 1'b0, 5);

    chk("scoreboard_empty", sbq.size(), 32'sd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/da_const_mult_seq.md
Name: da_const_mult_seq

Overview:
Parametrised multi-cycle constant multiplier: y = K * x for signed x, using distributed-arithmetic shift-add over BITS_PER_CYCLE input bits per clock.
Adds valid/ready handshakes, a true two's-complement sign-bit weight, and an optional rounding right-shift with saturation to OUT_W.
Used in the temperature-control datapath wherever a fixed gain (Kp/Ki scaling, sensor calibration) is applied without a DSP multiplier.

Parameters:
IN_W, 16, input sample width (signed)
K_W, 16, coefficient width (signed)
K, 2048, signed constant coefficient (K_W bits)
BITS_PER_CYCLE, 4, input bits consumed per RUN cycle; must divide IN_W (elaboration error otherwise)
OUT_SHIFT, 0, arithmetic right shift applied to full product with round-half-up (0 = none)
OUT_W, 32, output width (signed)
SATURATE, 1, 1 = clamp on overflow, 0 = wrap (truncate)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample (high only in IDLE)
in_x  in  IN_W  signed input sample
out_valid  out  1  result valid, held until accepted
out_ready  in  1  downstream accepts result
out_y  out  OUT_W  signed scaled result
out_sat  out  1  overflow flag for the result on out_y (valid with out_valid)
busy  out  1  high in RUN or FIN

Behaviour:
- Derived: P_W = IN_W+K_W, NCYC = IN_W/BITS_PER_CYCLE. Accumulator is P_W+1 bits signed.
- Reset (rst=1 at an edge): state IDLE, acc=0, cnt=0, out_valid=0, out_y=0, out_sat=0. Reset mid-RUN/FIN/DONE aborts; no result emitted, the pending sample is lost.
- FSM states: IDLE, RUN, FIN, DONE.
- IDLE: in_ready=1. Edge with in_valid=1: latch x, acc=0, cnt=0 -> RUN. Otherwise stay.
- RUN: in_ready=0. Each edge, for j in 0..BITS_PER_CYCLE-1 with bit index b = cnt*BITS_PER_CYCLE+j: add (K <<< b) if x[b]=1 and b<IN_W-1; subtract (K <<< b) if x[b]=1 and b=IN_W-1 (sign weight). cnt++. After edge where cnt = NCYC-1 -> FIN.
- FIN: one edge; computes r = (acc + (OUT_SHIFT>0 ? 2^(OUT_SHIFT-1) : 0)) >>> OUT_SHIFT. If r within signed OUT_W range: out_y=r, out_sat=0. Else out_sat=1 and out_y = clamp (max 2^(OUT_W-1)-1 / min -2^(OUT_W-1)) if SATURATE=1, else low OUT_W bits of r. Sets out_valid=1 -> DONE.
- DONE: out_valid=1, out_y/out_sat stable. Edge with out_ready=1: out_valid=0 -> IDLE. No new sample accepted in DONE (in_ready=0), even when out_ready=1 in the same cycle.
- Latency: acceptance edge E0; out_valid seen after edge E(NCYC+1) (defaults: 5 cycles). Min sample spacing NCYC+3 cycles.
- in_x changes after acceptance have no effect. out_ready while out_valid=0 ignored.
- Exact product, no rounding when OUT_SHIFT=0 and OUT_W >= P_W: out_sat never asserts.
- K=0: out_y=0. x = -2^(IN_W-1) and K = -2^(K_W-1): product +2^(P_W-2) fits P_W bits; check only output range.

Decomposition:
- Package da_pkg: state enum (IDLE/RUN/FIN/DONE), function for NCYC and P_W, signed-range min/max constant helpers.
- Sub-module da_round_sat (combinational, parameters IN_W_ACC, OUT_SHIFT, OUT_W, SATURATE): round-half-up shift, range check, clamp/wrap, sat flag. Reused by later filter blocks. Top holds FSM, counter, accumulator and output registers.

Test Plan:
- Defaults, x=3, out_ready=1 -> out_y=6144, out_sat=0, out_valid rises 5 cycles after acceptance, in_ready low during RUN/FIN/DONE.
- Defaults, x=-32768 -> out_y=-67108864; x=-1 -> -2048; x=32767 -> 67106816.
- K=-3, BITS_PER_CYCLE=1, x=-5 -> out_y=15, latency 17 cycles.
- OUT_W=16, SATURATE=1, x=100 -> out_y=32767, out_sat=1; x=-100 -> -32768, out_sat=1; with SATURATE=0, x=100 -> out_y=204800 mod 2^16 = 8192 (signed), out_sat=1.
- K=8, OUT_SHIFT=4: x=1 -> 1 (8+8>>4); x=-1 -> 0 (-8+8>>4); x=3 -> 2 (24+8=32>>4).
- out_ready held low 10 cycles in DONE -> out_y stable, in_ready=0, second in_valid ignored; rst pulse mid-RUN -> IDLE next cycle, out_valid never asserts, next sample computes correctly.
